// File: rtl/dt1_alu_pkg.sv
// rtl/dt1_alu_pkg.sv - shared RV32i ALU opcode definitions for dt1_alu and its arbiter
package dt1_alu_pkg;

  localparam int ALU_OP_W = 4;

  localparam logic [ALU_OP_W-1:0] ALU_ADD  = 4'b0000;
  localparam logic [ALU_OP_W-1:0] ALU_SUB  = 4'b0001;
  localparam logic [ALU_OP_W-1:0] ALU_AND  = 4'b0010;
  localparam logic [ALU_OP_W-1:0] ALU_OR   = 4'b0011;
  localparam logic [ALU_OP_W-1:0] ALU_SLL  = 4'b0100;
  localparam logic [ALU_OP_W-1:0] ALU_SLT  = 4'b0101;
  localparam logic [ALU_OP_W-1:0] ALU_SLTU = 4'b0110;
  localparam logic [ALU_OP_W-1:0] ALU_XOR  = 4'b0111;
  localparam logic [ALU_OP_W-1:0] ALU_SRA  = 4'b1000;
  localparam logic [ALU_OP_W-1:0] ALU_SRL  = 4'b1001;
  localparam logic [ALU_OP_W-1:0] ALU_BGE  = 4'b1010;
  localparam logic [ALU_OP_W-1:0] ALU_BGEU = 4'b1011;
  localparam logic [ALU_OP_W-1:0] ALU_BNE  = 4'b1100;

  localparam logic [ALU_OP_W-1:0] ALU_OP_MAX = 4'b1100;

  // Codes above ALU_OP_MAX have no ALU meaning.
  function automatic logic alu_op_legal(input logic [ALU_OP_W-1:0] op);
    return op <= ALU_OP_MAX;
  endfunction

endpackage

// File: rtl/dt1_rr_arb2.sv
// rtl/dt1_rr_arb2.sv - two-way round-robin grant with one bit of history
//
// Ports:
//   clk    in   clock
//   reset  in   asynchronous active-high reset
//   req    in   [1:0] eligible requesters
//   gnt    out  [1:0] one-hot (or zero) grant, combinational from req
module dt1_rr_arb2 (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  output logic [1:0] gnt
);

  // Index of the most recent winner; resets to 1 so requester 0 wins first.
  logic rr_last_q;
  logic rr_last_d;

  always_comb begin
    gnt = req;
    if (req == 2'b11) begin
      gnt = rr_last_q ? 2'b01 : 2'b10;
    end
  end

  // History only moves when somebody actually wins.
  always_comb begin
    rr_last_d = rr_last_q;
    if (|gnt) begin
      rr_last_d = gnt[1];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rr_last_q <= 1'b1;
    end else begin
      rr_last_q <= rr_last_d;
    end
  end

endmodule

// File: rtl/dt1_alu_arb2.sv
// rtl/dt1_alu_arb2.sv - shares one external dt1_alu between two valid/ready requesters
//
// Optional macro DT1_ALU_ARB_OPCHECK_EN: ops above ALU_OP_MAX are accepted but not
// forwarded to the ALU; their response is y=0, cond=0, err=1. Without it ops pass
// through unchanged and rN_rsp_err stays 0.
//
// Ports:
//   clk, reset                     clock, asynchronous active-high reset
//   rN_valid/rN_ready              request handshake (N = 0, 1)
//   rN_op/rN_a/rN_b                request payload
//   rN_rsp_valid/rN_rsp_ready      response handshake
//   rN_rsp_y/rN_rsp_cond/rN_rsp_err registered response payload
//   alu_control/alu_a/alu_b        drive to dt1_alu
//   alu_y/alu_cond                 result from dt1_alu
module dt1_alu_arb2
  import dt1_alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic                clk,
  input  logic                reset,

  input  logic                r0_valid,
  output logic                r0_ready,
  input  logic [ALU_OP_W-1:0] r0_op,
  input  logic [WIDTH-1:0]    r0_a,
  input  logic [WIDTH-1:0]    r0_b,
  output logic                r0_rsp_valid,
  input  logic                r0_rsp_ready,
  output logic [WIDTH-1:0]    r0_rsp_y,
  output logic                r0_rsp_cond,
  output logic                r0_rsp_err,

  input  logic                r1_valid,
  output logic                r1_ready,
  input  logic [ALU_OP_W-1:0] r1_op,
  input  logic [WIDTH-1:0]    r1_a,
  input  logic [WIDTH-1:0]    r1_b,
  output logic                r1_rsp_valid,
  input  logic                r1_rsp_ready,
  output logic [WIDTH-1:0]    r1_rsp_y,
  output logic                r1_rsp_cond,
  output logic                r1_rsp_err,

  output logic [ALU_OP_W-1:0] alu_control,
  output logic [WIDTH-1:0]    alu_a,
  output logic [WIDTH-1:0]    alu_b,
  input  logic [WIDTH-1:0]    alu_y,
  input  logic                alu_cond
);

  logic [1:0] rsp_valid_q;
  logic [1:0] rsp_valid_d;
  logic [1:0] rsp_cond_q;
  logic [1:0] rsp_err_q;
  logic [WIDTH-1:0] rsp_y_q [2];

  logic [1:0] req_valid;
  logic [1:0] rsp_ready;
  logic [1:0] slot_free;
  logic [1:0] eligible;
  logic [1:0] gnt;

  logic [ALU_OP_W-1:0] sel_op;
  logic [WIDTH-1:0]    sel_a;
  logic [WIDTH-1:0]    sel_b;
  logic                sel_illegal;

  logic [WIDTH-1:0] cap_y;
  logic             cap_cond;
  logic             cap_err;

  assign req_valid = {r1_valid, r0_valid};
  assign rsp_ready = {r1_rsp_ready, r0_rsp_ready};

  // A slot being drained this cycle can take a new result on the same edge.
  assign slot_free = ~rsp_valid_q | rsp_ready;
  assign eligible  = req_valid & slot_free;

  dt1_rr_arb2 u_rr_arb (
    .clk   (clk),
    .reset (reset),
    .req   (eligible),
    .gnt   (gnt)
  );

  assign r0_ready = gnt[0];
  assign r1_ready = gnt[1];

  // Payload of whichever requester holds the grant (only meaningful when |gnt).
  assign sel_op = gnt[1] ? r1_op : r0_op;
  assign sel_a  = gnt[1] ? r1_a  : r0_a;
  assign sel_b  = gnt[1] ? r1_b  : r0_b;

`ifdef DT1_ALU_ARB_OPCHECK_EN
  assign sel_illegal = (|gnt) && !alu_op_legal(sel_op);
`else
  assign sel_illegal = 1'b0;
`endif

  // The ALU sees zeros when idle or when the granted op is being suppressed.
  always_comb begin
    alu_control = ALU_ADD;
    alu_a       = '0;
    alu_b       = '0;
    if ((|gnt) && !sel_illegal) begin
      alu_control = sel_op;
      alu_a       = sel_a;
      alu_b       = sel_b;
    end
  end

  assign cap_y    = sel_illegal ? '0 : alu_y;
  assign cap_cond = sel_illegal ? 1'b0 : alu_cond;
  assign cap_err  = sel_illegal;

  // A grant refills the slot; otherwise a consumed response empties it.
  always_comb begin
    rsp_valid_d = rsp_valid_q;
    for (int n = 0; n < 2; n++) begin
      if (gnt[n]) begin
        rsp_valid_d[n] = 1'b1;
      end else if (rsp_ready[n]) begin
        rsp_valid_d[n] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rsp_valid_q <= '0;
      rsp_cond_q  <= '0;
      rsp_err_q   <= '0;
      rsp_y_q[0]  <= '0;
      rsp_y_q[1]  <= '0;
    end else begin
      rsp_valid_q <= rsp_valid_d;
      for (int n = 0; n < 2; n++) begin
        if (gnt[n]) begin
          rsp_y_q[n]    <= cap_y;
          rsp_cond_q[n] <= cap_cond;
          rsp_err_q[n]  <= cap_err;
        end
      end
    end
  end

  assign r0_rsp_valid = rsp_valid_q[0];
  assign r0_rsp_y     = rsp_y_q[0];
  assign r0_rsp_cond  = rsp_cond_q[0];
  assign r0_rsp_err   = rsp_err_q[0];

  assign r1_rsp_valid = rsp_valid_q[1];
  assign r1_rsp_y     = rsp_y_q[1];
  assign r1_rsp_cond  = rsp_cond_q[1];
  assign r1_rsp_err   = rsp_err_q[1];

endmodule

// File: tb/tb_dt1_alu_arb2.sv
// tb/tb_dt1_alu_arb2.sv - directed self-checking bench for dt1_alu_arb2
module tb_dt1_alu_arb2;
  import dt1_alu_pkg::*;

  localparam int WIDTH = 32;

  logic clk = 1'b0;
  logic reset = 1'b0;

  logic             r0_valid = 1'b0, r0_ready, r0_rsp_valid, r0_rsp_ready = 1'b0;
  logic [3:0]       r0_op = '0;
  logic [WIDTH-1:0] r0_a = '0, r0_b = '0, r0_rsp_y;
  logic             r0_rsp_cond, r0_rsp_err;

  logic             r1_valid = 1'b0, r1_ready, r1_rsp_valid, r1_rsp_ready = 1'b0;
  logic [3:0]       r1_op = '0;
  logic [WIDTH-1:0] r1_a = '0, r1_b = '0, r1_rsp_y;
  logic             r1_rsp_cond, r1_rsp_err;

  logic [3:0]       alu_control;
  logic [WIDTH-1:0] alu_a, alu_b, alu_y;
  logic             alu_cond;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  dt1_alu_arb2 #(.WIDTH(WIDTH)) dut (
    .clk          (clk),
    .reset        (reset),
    .r0_valid     (r0_valid),
    .r0_ready     (r0_ready),
    .r0_op        (r0_op),
    .r0_a         (r0_a),
    .r0_b         (r0_b),
    .r0_rsp_valid (r0_rsp_valid),
    .r0_rsp_ready (r0_rsp_ready),
    .r0_rsp_y     (r0_rsp_y),
    .r0_rsp_cond  (r0_rsp_cond),
    .r0_rsp_err   (r0_rsp_err),
    .r1_valid     (r1_valid),
    .r1_ready     (r1_ready),
    .r1_op        (r1_op),
    .r1_a         (r1_a),
    .r1_b         (r1_b),
    .r1_rsp_valid (r1_rsp_valid),
    .r1_rsp_ready (r1_rsp_ready),
    .r1_rsp_y     (r1_rsp_y),
    .r1_rsp_cond  (r1_rsp_cond),
    .r1_rsp_err   (r1_rsp_err),
    .alu_control  (alu_control),
    .alu_a        (alu_a),
    .alu_b        (alu_b),
    .alu_y        (alu_y),
    .alu_cond     (alu_cond)
  );

  // Stand-in for the external dt1_alu.
  always_comb begin
    alu_y    = '0;
    alu_cond = 1'b0;
    case (alu_control)
      ALU_ADD:  alu_y = alu_a + alu_b;
      ALU_SUB:  begin alu_y = alu_a - alu_b; alu_cond = (alu_a == alu_b); end
      ALU_AND:  alu_y = alu_a & alu_b;
      ALU_OR:   alu_y = alu_a | alu_b;
      ALU_SLL:  alu_y = alu_a << alu_b[4:0];
      ALU_SLT:  begin alu_cond = ($signed(alu_a) < $signed(alu_b)); alu_y = {31'd0, alu_cond}; end
      ALU_SLTU: begin alu_cond = (alu_a < alu_b); alu_y = {31'd0, alu_cond}; end
      ALU_XOR:  alu_y = alu_a ^ alu_b;
      ALU_SRA:  alu_y = $unsigned($signed(alu_a) >>> alu_b[4:0]);
      ALU_SRL:  alu_y = alu_a >> alu_b[4:0];
      ALU_BGE:  begin alu_y = alu_a - alu_b; alu_cond = ($signed(alu_a) >= $signed(alu_b)); end
      ALU_BGEU: begin alu_y = alu_a - alu_b; alu_cond = (alu_a >= alu_b); end
      ALU_BNE:  begin alu_y = alu_a - alu_b; alu_cond = (alu_a != alu_b); end
      default:  begin alu_y = 32'hDEAD_BEEF; alu_cond = 1'b1; end
    endcase
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic drive0(input logic v, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    r0_valid = v; r0_op = op; r0_a = a; r0_b = b;
  endtask

  task automatic drive1(input logic v, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    r1_valid = v; r1_op = op; r1_a = a; r1_b = b;
  endtask

  // Advance one rising edge and settle just after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    #2;
    reset = 1'b0;
    #1;
  endtask

  initial begin
    do_reset();

    // Reset state and idle ALU drive
    check("rst_r0_rsp_valid", {31'd0, r0_rsp_valid}, 32'd0);
    check("rst_r1_rsp_valid", {31'd0, r1_rsp_valid}, 32'd0);
    check("rst_r0_rsp_y", r0_rsp_y, 32'd0);
    check("rst_r1_rsp_err", {31'd0, r1_rsp_err}, 32'd0);
    check("idle_alu_ctl", {28'd0, alu_control}, 32'd0);
    check("idle_alu_a", alu_a, 32'd0);

    // 1: single ADD
    drive0(1'b1, ALU_ADD, 32'd5, 32'd7);
    #1;
    check("t1_r0_ready", {31'd0, r0_ready}, 32'd1);
    check("t1_r1_ready", {31'd0, r1_ready}, 32'd0);
    check("t1_alu_a", alu_a, 32'd5);
    check("t1_alu_b", alu_b, 32'd7);
    step();
    drive0(1'b0, ALU_ADD, 32'd0, 32'd0);
    check("t1_rsp_valid", {31'd0, r0_rsp_valid}, 32'd1);
    check("t1_rsp_y", r0_rsp_y, 32'd12);
    check("t1_rsp_cond", {31'd0, r0_rsp_cond}, 32'd0);
    r0_rsp_ready = 1'b1;
    step();
    check("t1_rsp_cleared", {31'd0, r0_rsp_valid}, 32'd0);
    check("t1_rsp_y_hold", r0_rsp_y, 32'd12);

    // 2: contention from reset alternates 0,1,0,1
    do_reset();
    r0_rsp_ready = 1'b1;
    r1_rsp_ready = 1'b1;
    drive0(1'b1, ALU_SUB, 32'd3, 32'd3);
    drive1(1'b1, ALU_BNE, 32'd3, 32'd4);
    #1;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("t2_r0_ready_%0d", i), {31'd0, r0_ready}, (i % 2 == 0) ? 32'd1 : 32'd0);
      check($sformatf("t2_r1_ready_%0d", i), {31'd0, r1_ready}, (i % 2 == 0) ? 32'd0 : 32'd1);
      step();
      if (i % 2 == 0) begin
        check($sformatf("t2_r0_valid_%0d", i), {31'd0, r0_rsp_valid}, 32'd1);
        check($sformatf("t2_r0_y_%0d", i), r0_rsp_y, 32'd0);
        check($sformatf("t2_r0_cond_%0d", i), {31'd0, r0_rsp_cond}, 32'd1);
      end else begin
        check($sformatf("t2_r1_valid_%0d", i), {31'd0, r1_rsp_valid}, 32'd1);
        check($sformatf("t2_r1_y_%0d", i), r1_rsp_y, 32'hFFFF_FFFF);
        check($sformatf("t2_r1_cond_%0d", i), {31'd0, r1_rsp_cond}, 32'd1);
        check($sformatf("t2_r0_drained_%0d", i), {31'd0, r0_rsp_valid}, 32'd0);
      end
    end
    drive0(1'b0, ALU_ADD, 32'd0, 32'd0);
    drive1(1'b0, ALU_ADD, 32'd0, 32'd0);
    step();

    // 3: backpressure on r0, r1 served every cycle, then release
    r0_rsp_ready = 1'b0;
    drive0(1'b1, ALU_ADD, 32'd1, 32'd1);
    #1;
    check("t3_first_accept", {31'd0, r0_ready}, 32'd1);
    step();
    check("t3_pending_y", r0_rsp_y, 32'd2);
    drive0(1'b1, ALU_ADD, 32'd10, 32'd20);
    drive1(1'b1, ALU_ADD, 32'd100, 32'd1);
    #1;
    for (int i = 0; i < 3; i++) begin
      check($sformatf("t3_r0_blocked_%0d", i), {31'd0, r0_ready}, 32'd0);
      check($sformatf("t3_r1_served_%0d", i), {31'd0, r1_ready}, 32'd1);
      step();
      check($sformatf("t3_r0_hold_y_%0d", i), r0_rsp_y, 32'd2);
      check($sformatf("t3_r0_hold_v_%0d", i), {31'd0, r0_rsp_valid}, 32'd1);
      check($sformatf("t3_r1_y_%0d", i), r1_rsp_y, 32'd101);
    end
    r0_rsp_ready = 1'b1;
    #1;
    check("t3_r0_release_ready", {31'd0, r0_ready}, 32'd1);
    check("t3_r1_waits", {31'd0, r1_ready}, 32'd0);
    step();
    check("t3_r0_new_y", r0_rsp_y, 32'd30);
    check("t3_r0_new_valid", {31'd0, r0_rsp_valid}, 32'd1);

    // 4: asynchronous reset mid-cycle with r1 response pending
    drive0(1'b0, ALU_ADD, 32'd0, 32'd0);
    drive1(1'b1, ALU_ADD, 32'd7, 32'd8);
    r1_rsp_ready = 1'b0;
    step();
    drive1(1'b0, ALU_ADD, 32'd0, 32'd0);
    drive0(1'b1, ALU_ADD, 32'd1, 32'd2);
    step();
    drive0(1'b0, ALU_ADD, 32'd0, 32'd0);
    check("t4_pre_r1_valid", {31'd0, r1_rsp_valid}, 32'd1);
    check("t4_pre_r1_y", r1_rsp_y, 32'd15);
    #1;
    reset = 1'b1;
    #1;
    check("t4_async_r1_valid", {31'd0, r1_rsp_valid}, 32'd0);
    check("t4_async_r1_y", r1_rsp_y, 32'd0);
    check("t4_async_r0_valid", {31'd0, r0_rsp_valid}, 32'd0);
    reset = 1'b0;
    r0_rsp_ready = 1'b1;
    r1_rsp_ready = 1'b1;
    drive0(1'b1, ALU_ADD, 32'd2, 32'd2);
    drive1(1'b1, ALU_ADD, 32'd3, 32'd3);
    #1;
    check("t4_first_r0", {31'd0, r0_ready}, 32'd1);
    check("t4_first_r1", {31'd0, r1_ready}, 32'd0);
    step();
    drive1(1'b0, ALU_ADD, 32'd0, 32'd0);

    // 5: signed vs unsigned compare
    drive0(1'b1, ALU_SLT, 32'hFFFF_FFFF, 32'd1);
    step();
    check("t5_slt_y", r0_rsp_y, 32'd1);
    check("t5_slt_cond", {31'd0, r0_rsp_cond}, 32'd1);
    drive0(1'b1, ALU_SLTU, 32'hFFFF_FFFF, 32'd1);
    step();
    check("t5_sltu_y", r0_rsp_y, 32'd0);
    check("t5_sltu_cond", {31'd0, r0_rsp_cond}, 32'd0);
    check("t5_sltu_err", {31'd0, r0_rsp_err}, 32'd0);

    // 6: out-of-range opcode
    drive0(1'b1, 4'b1111, 32'd9, 32'd9);
    #1;
    check("t6_ready", {31'd0, r0_ready}, 32'd1);
`ifdef DT1_ALU_ARB_OPCHECK_EN
    check("t6_alu_ctl", {28'd0, alu_control}, 32'd0);
    check("t6_alu_a", alu_a, 32'd0);
    step();
    check("t6_y", r0_rsp_y, 32'd0);
    check("t6_cond", {31'd0, r0_rsp_cond}, 32'd0);
    check("t6_err", {31'd0, r0_rsp_err}, 32'd1);
`else
    check("t6_alu_ctl", {28'd0, alu_control}, 32'd15);
    check("t6_alu_a", alu_a, 32'd9);
    step();
    check("t6_y", r0_rsp_y, 32'hDEAD_BEEF);
    check("t6_err", {31'd0, r0_rsp_err}, 32'd0);
`endif
    drive0(1'b1, ALU_ADD, 32'd2, 32'd2);
    step();
    check("t6_legal_y", r0_rsp_y, 32'd4);
    check("t6_legal_err", {31'd0, r0_rsp_err}, 32'd0);
    drive0(1'b0, ALU_ADD, 32'd0, 32'd0);
    step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/dt1_alu_arb2.md
Name: dt1_alu_arb2

Overview:
Two-port round-robin arbiter/sequencer that shares the single combinational RV32i ALU (dt1_alu) between two requesters, e.g. the execute stage and the branch/address unit. It accepts operation requests over valid/ready, drives the ALU control and operand inputs for the granted requester, and registers the ALU result into a per-requester response slot. Responses are returned over valid/ready. The block sits between the requesters and an externally instantiated dt1_alu.

Parameters:
WIDTH, 32, datapath width of operands and result.

Ports:
clk  in  1  clock; all state updates on rising edge
reset  in  1  asynchronous, active-high reset
r0_valid  in  1  requester 0 operation request
r0_ready  out  1  requester 0 request accepted this cycle
r0_op  in  4  ALU control code (dt1_alu encoding)
r0_a  in  WIDTH  operand a
r0_b  in  WIDTH  operand b
r0_rsp_valid  out  1  requester 0 response available
r0_rsp_ready  in  1  requester 0 consumes response
r0_rsp_y  out  WIDTH  registered ALU result
r0_rsp_cond  out  1  registered BranchCond
r0_rsp_err  out  1  illegal-op flag (see Optional Feature)
r1_*  same set of nine ports for requester 1
alu_control  out  4  to dt1_alu control
alu_a  out  WIDTH  to dt1_alu a
alu_b  out  WIDTH  to dt1_alu b
alu_y  in  WIDTH  from dt1_alu y
alu_cond  in  1  from dt1_alu BranchCond

Behaviour:
- Reset values: all rN_rsp_valid=0, rsp_y=0, rsp_cond=0, rsp_err=0, rr_last=1 (requester 0 wins the first contention).
- Slot free for N: !rN_rsp_valid || rN_rsp_ready.
- Eligible for N: rN_valid && slot free for N.
- Grant, combinational:
  - one eligible: that requester wins;
  - both eligible: the requester != rr_last wins;
  - none eligible: no grant.
- rN_ready = grant_N; at most one rN_ready is high per cycle.
- rN_ready depends combinationally on rN_valid and rN_rsp_ready. Requesters must not make valid depend on ready.
- ALU drive:
  - with a grant: alu_control/alu_a/alu_b come from the granted requester;
  - without a grant: alu_control=4'b0000, alu_a=0, alu_b=0.
- On the rising edge with grant N:
  - rN_rsp_y <= alu_y, rN_rsp_cond <= alu_cond, rN_rsp_valid <= 1;
  - rr_last <= N.
- On the rising edge with rN_rsp_valid && rN_rsp_ready and no grant to N: rN_rsp_valid <= 0. Data holds.
- rr_last changes only on a grant.
- Latency: accept in cycle T, response visible in cycle T+1. Aggregate throughput is one op/cycle. A single requester with rsp_ready held high also gets one op/cycle.
- Backpressure: while rN_rsp_valid=1 and rN_rsp_ready=0, rN_ready=0 and the other requester is served every cycle.
- Response payload is stable while rN_rsp_valid=1 and rN_rsp_ready=0.
- Reset asserted mid-operation clears all state immediately without waiting for a clock. A request in flight is dropped, not replayed.
- No width conversion: the ALU result is captured verbatim.

Optional Feature:
Macro DT1_ALU_ARB_OPCHECK_EN.
- Defined:
  - ops 4'b1101–4'b1111 are accepted normally (grant, ready, rr update) but not forwarded; alu_control/a/b driven to 0;
  - response is y=0, cond=0, err=1;
  - legal ops give err=0.
- Undefined: ops are forwarded unchanged and rN_rsp_err is tied 0.

Decomposition:
- Shared package dt1_alu_pkg holds:
  - ALU_OP_W=4;
  - localparams ALU_ADD=4'b0000, ALU_SUB, ALU_AND, ALU_OR, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR, ALU_SRA, ALU_SRL, ALU_BGE, ALU_BGEU, ALU_BNE=4'b1100;
  - ALU_OP_MAX=4'b1100.
- dt1_alu uses the same package.
- One sub-module: dt1_rr_arb2.
  - Inputs: clk, reset, req[1:0]. Outputs: gnt[1:0]. Internal state: rr_last.
  - Response slots stay in the top level.

Test Plan:
1. r0 ADD a=5 b=7, r1 idle -> r0_ready=1 same cycle; next cycle r0_rsp_valid=1, y=12, cond=0; r0_rsp_ready=1 clears valid the following cycle.
2. Both valid continuously, both rsp_ready=1, starting from reset -> grants 0,1,0,1.
   - r0 SUB 3,3 -> y=0, cond=1;
   - r1 BNE 3,4 -> y=0xFFFFFFFF, cond=1.
3. r0_rsp_ready=0 with a response pending and r0 requesting again -> r0_ready=0, r1 granted each cycle. Raising r0_rsp_ready makes r0 eligible that same cycle; the new result replaces the old on that edge.
4. reset pulsed between clock edges while r1_rsp_valid=1 -> r1_rsp_valid=0 and y=0 immediately; with both requesting after release, first grant goes to r0.
5. SLT a=0xFFFFFFFF b=1 -> y=1, cond=1; SLTU same operands -> y=0, cond=0.
6. With DT1_ALU_ARB_OPCHECK_EN: r0 op 4'b1111 -> alu_control=0, next cycle y=0, cond=0, err=1; a subsequent legal op gives err=0.
